gpr_writeback: RTL and testbench

GPR_WRITEBACK -- requirements
Module: gpr_writeback

---
 rtl/gpr_pkg.sv | 20 ++
 rtl/wb_fifo.sv | 60 ++++++
 rtl/gpr_writeback.sv | 95 +++++++++
 tb/tb_gpr_writeback.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/gpr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gpr_pkg
// Brief    : Shared register-file constants and the write-buffer entry type.
// Revision : 1.0 - initial release
// ============================================================================
package gpr_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int DATA_W     = 32;

  // Default-width entry; wider or narrower datapaths pass their own entry type.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Brief    : Power-of-two depth FIFO of write-back entries, push/pop/full/empty.
// Revision : 1.0 - initial release
// ============================================================================
module wb_fifo
  import gpr_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type ENTRY_T = wb_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  ENTRY_T din,
  input  logic   pop,
  output ENTRY_T dout,
  output logic   full,
  output logic   empty
);

  localparam int                 c_PTR_W    = $clog2(DEPTH);
  localparam logic [c_PTR_W:0]   c_FULL_CNT = DEPTH[c_PTR_W:0];
  localparam logic [c_PTR_W:0]   c_CNT_ONE  = (c_PTR_W+1)'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

  ENTRY_T               r_mem [DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_PTR_W:0]     r_count;
  logic                 w_push;
  logic                 w_pop;

  assign full   = (r_count == c_FULL_CNT);
  assign empty  = (r_count == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign dout   = r_mem[r_rd_ptr];

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      if (w_push && !w_pop)      r_count <= r_count + c_CNT_ONE;
      else if (w_pop && !w_push) r_count <= r_count - c_CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/gpr_writeback.sv
`default_nettype none
// ============================================================================
// Module   : gpr_writeback
// Brief    : Arbitrates LSU/ALU results into a write buffer, drains it to the
//            register-file write port and tracks pending writes.
// Revision : 1.0 - initial release
// ============================================================================
module gpr_writeback
  import gpr_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [N-1:0]          lsu_data,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [N-1:0]          alu_data,
  input  logic                  wb_hold,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic                  WE3,
  output logic [REG_ADDR_W-1:0] A3,
  output logic [N-1:0]          WD3,
  output logic [NUM_REGS-1:0]   busy
);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [N-1:0]          data;
  } entry_t;

  localparam logic [NUM_REGS-1:0] c_X0_MASK = {{(NUM_REGS-1){1'b1}}, 1'b0};

  entry_t              w_din;
  entry_t              w_head;
  logic                w_full;
  logic                w_empty;
  logic                w_lsu_fire;
  logic                w_alu_fire;
  logic                w_push;
  logic [NUM_REGS-1:0] w_set;
  logic [NUM_REGS-1:0] w_clr;
  logic [NUM_REGS-1:0] r_busy;

  // LSU has fixed priority, so at most one source transfers per cycle.
  assign lsu_ready  = !rst && !w_full;
  assign alu_ready  = !rst && !w_full && !lsu_valid;
  assign w_lsu_fire = lsu_valid && lsu_ready;
  assign w_alu_fire = alu_valid && alu_ready;

  // Results for x0 complete the handshake but never enter the buffer.
  assign w_push = (w_lsu_fire && (lsu_rd != '0)) || (w_alu_fire && (alu_rd != '0));
  assign w_din  = w_lsu_fire ? entry_t'{rd: lsu_rd, data: lsu_data}
                             : entry_t'{rd: alu_rd, data: alu_data};

  assign WE3  = !rst && !w_empty && !wb_hold;
  assign A3   = w_head.rd;
  assign WD3  = w_head.data;
  assign busy = r_busy;

  wb_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_T (entry_t)
  ) u_wb_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   (w_din),
    .pop   (WE3),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (issue_valid && (issue_rd != '0)) w_set[issue_rd] = 1'b1;
    if (WE3)                             w_clr[A3]       = 1'b1;
  end

  // Set is applied after clear so a re-issue in the commit cycle stays pending.
  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= ((r_busy & ~w_clr) | w_set) & c_X0_MASK;
  end

endmodule
`default_nettype wire

// File: tb/tb_gpr_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpr_writeback
// Brief    : Directed and randomized stimulus against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpr_writeback;

  localparam int N     = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          lsu_valid, alu_valid, wb_hold, issue_valid;
  logic          lsu_ready, alu_ready, WE3;
  logic [4:0]    lsu_rd, alu_rd, issue_rd, A3;
  logic [N-1:0]  lsu_data, alu_data, WD3;
  logic [31:0]   busy;

  gpr_writeback #(.N(N), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .wb_hold     (wb_hold),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .WE3         (WE3),
    .A3          (A3),
    .WD3         (WD3),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: pending writes as an ordered list, busy as a plain bit set.
  typedef struct {
    logic [4:0]   rd;
    logic [N-1:0] data;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mbusy = '0;

  always @(negedge clk) begin
    logic e_full, e_lr, e_ar, e_we;
    ent_t e;
    e_full = (mq.size() == DEPTH);
    e_lr   = !rst && !e_full;
    e_ar   = e_lr && !lsu_valid;
    e_we   = !rst && (mq.size() != 0) && !wb_hold;
    check("lsu_ready", 64'(lsu_ready), 64'(e_lr));
    check("alu_ready", 64'(alu_ready), 64'(e_ar));
    check("WE3",       64'(WE3),       64'(e_we));
    if (e_we) begin
      check("A3",  64'(A3),  64'(mq[0].rd));
      check("WD3", 64'(WD3), 64'(mq[0].data));
    end
    check("busy", 64'(busy), 64'(mbusy));

    if (rst) begin
      mq.delete();
      mbusy = '0;
    end else begin
      if (e_we) begin
        mbusy[mq[0].rd] = 1'b0;
        void'(mq.pop_front());
      end
      if (lsu_valid && e_lr) begin
        if (lsu_rd != 0) begin e.rd = lsu_rd; e.data = lsu_data; mq.push_back(e); end
      end else if (alu_valid && e_ar) begin
        if (alu_rd != 0) begin e.rd = alu_rd; e.data = alu_data; mq.push_back(e); end
      end
      if (issue_valid && issue_rd != 0) mbusy[issue_rd] = 1'b1;
    end
  end

  task automatic cyc(input logic lv, input logic [4:0] lrd, input logic [N-1:0] ld,
                     input logic av, input logic [4:0] ard, input logic [N-1:0] ad,
                     input logic hold, input logic iv, input logic [4:0] ird, input logic r);
    lsu_valid = lv;  lsu_rd = lrd;  lsu_data = ld;
    alu_valid = av;  alu_rd = ard;  alu_data = ad;
    wb_hold = hold;  issue_valid = iv;  issue_rd = ird;  rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);

    // single write to x5
    cyc(1, 5, 32'h5, 0, 0, 0, 0, 1, 5, 0);
    idle(3);

    // LSU/ALU collision; ALU held until accepted
    cyc(1, 6, 32'h4, 1, 7, 32'h9, 0, 0, 0, 0);
    cyc(0, 0, 0,     1, 7, 32'h9, 0, 0, 0, 0);
    idle(3);

    // fill under hold, then drain
    for (int i = 1; i <= 4; i++) cyc(1, 5'(i), 32'(i * 16), 0, 0, 0, 1, 0, 0, 0);
    cyc(1, 8, 32'h88, 1, 9, 32'h99, 1, 0, 0, 0);
    idle(6);

    // x0 drop
    cyc(0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0, 1, 0, 0);
    idle(3);

    // re-issue in the commit cycle keeps x9 pending
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
    cyc(0, 0, 0, 1, 9, 32'h11, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
    cyc(0, 0, 0, 1, 9, 32'h22, 0, 0, 0, 0);
    idle(3);

    // reset with buffered entries
    for (int i = 1; i <= 3; i++) cyc(1, 5'(i + 10), 32'(i), 0, 0, 0, 1, 1, 5'(i + 10), 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    idle(4);

    // randomized traffic with varying backpressure
    for (int i = 0; i < 3000; i++) begin
      int hold_pct;
      hold_pct = (i / 500) * 15;
      cyc(($urandom_range(0, 99) < 50), 5'($urandom_range(0, 7)), $urandom,
          ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom,
          ($urandom_range(0, 99) < hold_pct),
          ($urandom_range(0, 99) < 40), 5'($urandom_range(0, 7)),
          ($urandom_range(0, 199) == 0));
    end
    idle(8);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
